// File: rtl/apple_iie_ram_sequencer.sv
// apple_iie_ram_sequencer
// Main-RAM DRAM sequencer. Each 1 MHz cycle is 14 ticks of clk_14M, split into
// a video slot (ticks 0-6, phi0=0) and a CPU slot (ticks 7-13, phi0=1). Each
// slot runs one RAS cycle: row on s0-s1, column on s2-s6, RAS low s1-s5 and
// CAS low s3-s5 when the slot performs an access. With video disabled, the
// video slot becomes a RAS-only refresh of an incrementing row counter.
//
// Optional feature macro: LONG_CYCLE_EN. When defined, the parameter
// LONG_CYCLE_PERIOD exists and the last cycle of every group of
// LONG_CYCLE_PERIOD cycles is stretched to 16 ticks (CPU s6 covers ticks 13-15).
//
// Read return: cpu_rvalid / video_rvalid are single-tick pulses with no
// backpressure; the matching rdata is valid during the pulse and holds its
// value until the next completed read of that requester.
//
// All outputs are registered: the value seen during tick t is the value loaded
// on the edge that enters t, so every output is computed from the next tick.

module apple_iie_ram_sequencer #(
    parameter int REFRESH_W = 8
`ifdef LONG_CYCLE_EN
    ,
    parameter int LONG_CYCLE_PERIOD = 65
`endif
) (
    input  logic        clk_14M,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic        cpu_rw_n,
    input  logic        cpu_en,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        video_en,
    input  logic [15:0] video_a,
    output logic [7:0]  video_rdata,
    output logic        video_rvalid,
    output logic        phi0,
    output logic [7:0]  ra,
    output logic        ras_n,
    output logic        cas_n,
    output logic        rw_n,
    output logic [7:0]  d_o,
    output logic        d_oe,
    input  logic [7:0]  d_i
);

`ifdef LONG_CYCLE_EN
    localparam int CW = (LONG_CYCLE_PERIOD > 1) ? $clog2(LONG_CYCLE_PERIOD) : 1;
    logic [CW-1:0] cyc_q, cyc_d;
`endif

    // Sequencer state: tick counter and refresh row.
    logic [3:0]           t_q, t_d;
    logic [REFRESH_W-1:0] ref_q, ref_d;

    // Request latches, loaded at the start of their slot.
    logic [15:0] cpu_a_q, cpu_a_d;
    logic        cpu_rw_n_q, cpu_rw_n_d;
    logic        cpu_en_q, cpu_en_d;
    logic [7:0]  cpu_wdata_q, cpu_wdata_d;
    logic [15:0] vid_a_q, vid_a_d;
    logic        vid_en_q, vid_en_d;

    // Registered outputs.
    logic       phi0_q, phi0_d;
    logic [7:0] ra_q, ra_d;
    logic       ras_n_q, ras_n_d;
    logic       cas_n_q, cas_n_d;
    logic       rw_n_q, rw_n_d;
    logic [7:0] d_o_q, d_o_d;
    logic       d_oe_q, d_oe_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;
    logic [7:0] video_rdata_q, video_rdata_d;
    logic       video_rvalid_q, video_rvalid_d;

    // Decode helpers for the tick being entered.
    logic [3:0]  last_tick;
    logic [3:0]  s;
    logic        cpu_sample, vid_sample;
    logic        cpu_slot;
    logic        access, refresh, wr;
    logic [15:0] addr;
    logic [7:0]  ref_row;

    // Next tick, request capture and per-slot strobe/address generation.
    always_comb begin
        last_tick = 4'd13;
`ifdef LONG_CYCLE_EN
        cyc_d = cyc_q;
        if (cyc_q == CW'(LONG_CYCLE_PERIOD - 1)) begin
            last_tick = 4'd15;
        end
        if (t_q == last_tick) begin
            cyc_d = (cyc_q == CW'(LONG_CYCLE_PERIOD - 1)) ? '0 : cyc_q + CW'(1);
        end
`endif
        t_d        = (t_q == last_tick) ? 4'd0 : t_q + 4'd1;
        cpu_sample = (t_q == 4'd6);
        vid_sample = (t_q == last_tick);

        // The slot about to start uses the inputs directly; later ticks use the latch.
        cpu_a_d     = cpu_sample ? cpu_a     : cpu_a_q;
        cpu_rw_n_d  = cpu_sample ? cpu_rw_n  : cpu_rw_n_q;
        cpu_en_d    = cpu_sample ? cpu_en    : cpu_en_q;
        cpu_wdata_d = cpu_sample ? cpu_wdata : cpu_wdata_q;
        vid_a_d     = vid_sample ? video_a   : vid_a_q;
        vid_en_d    = vid_sample ? video_en  : vid_en_q;

        // Refresh row advances when a refresh slot finishes its s6.
        ref_d   = (t_q == 4'd6 && !vid_en_q) ? ref_q + REFRESH_W'(1) : ref_q;
        ref_row = 8'(ref_q);

        cpu_slot = (t_d >= 4'd7);
        s        = cpu_slot ? t_d - 4'd7 : t_d;
        if (cpu_slot) begin
            addr    = cpu_a_d;
            access  = cpu_en_d;
            refresh = 1'b0;
        end else begin
            addr    = vid_a_d;
            access  = vid_en_d;
            refresh = !vid_en_d;
        end

        wr = cpu_slot && cpu_en_d && !cpu_rw_n_d && (s >= 4'd2) && (s <= 4'd5);

        phi0_d  = cpu_slot;
        ra_d    = refresh ? ref_row : ((s >= 4'd2) ? addr[15:8] : addr[7:0]);
        ras_n_d = !((s >= 4'd1) && (s <= 4'd5));
        cas_n_d = !(access && (s >= 4'd3) && (s <= 4'd5));
        rw_n_d  = !wr;
        d_oe_d  = wr;
        d_o_d   = wr ? cpu_wdata_d : 8'h00;

        // Entering s6 is the s5->s6 edge where read data is captured.
        cpu_rvalid_d   = (t_d == 4'd13) && cpu_en_d && cpu_rw_n_d;
        cpu_rdata_d    = cpu_rvalid_d ? d_i : cpu_rdata_q;
        video_rvalid_d = (t_d == 4'd6) && vid_en_d;
        video_rdata_d  = video_rvalid_d ? d_i : video_rdata_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_14M) begin
        if (reset) begin
            t_q            <= 4'd0;
            ref_q          <= '0;
            cpu_a_q        <= 16'h0000;
            cpu_rw_n_q     <= 1'b1;
            cpu_en_q       <= 1'b0;
            cpu_wdata_q    <= 8'h00;
            vid_a_q        <= video_a;
            vid_en_q       <= video_en;
            phi0_q         <= 1'b0;
            ra_q           <= 8'h00;
            ras_n_q        <= 1'b1;
            cas_n_q        <= 1'b1;
            rw_n_q         <= 1'b1;
            d_o_q          <= 8'h00;
            d_oe_q         <= 1'b0;
            cpu_rdata_q    <= 8'h00;
            cpu_rvalid_q   <= 1'b0;
            video_rdata_q  <= 8'h00;
            video_rvalid_q <= 1'b0;
`ifdef LONG_CYCLE_EN
            cyc_q          <= '0;
`endif
        end else begin
            t_q            <= t_d;
            ref_q          <= ref_d;
            cpu_a_q        <= cpu_a_d;
            cpu_rw_n_q     <= cpu_rw_n_d;
            cpu_en_q       <= cpu_en_d;
            cpu_wdata_q    <= cpu_wdata_d;
            vid_a_q        <= vid_a_d;
            vid_en_q       <= vid_en_d;
            phi0_q         <= phi0_d;
            ra_q           <= ra_d;
            ras_n_q        <= ras_n_d;
            cas_n_q        <= cas_n_d;
            rw_n_q         <= rw_n_d;
            d_o_q          <= d_o_d;
            d_oe_q         <= d_oe_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_rvalid_q   <= cpu_rvalid_d;
            video_rdata_q  <= video_rdata_d;
            video_rvalid_q <= video_rvalid_d;
`ifdef LONG_CYCLE_EN
            cyc_q          <= cyc_d;
`endif
        end
    end

    assign phi0         = phi0_q;
    assign ra           = ra_q;
    assign ras_n        = ras_n_q;
    assign cas_n        = cas_n_q;
    assign rw_n         = rw_n_q;
    assign d_o          = d_o_q;
    assign d_oe         = d_oe_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rvalid   = cpu_rvalid_q;
    assign video_rdata  = video_rdata_q;
    assign video_rvalid = video_rvalid_q;

endmodule
